// File: rtl/sprite_blit_engine_if.sv
// Link between the blit engine and the SDRAM read master:
// burst control on the ctl_* side, show-ahead byte FIFO on the usr_* side.
interface sprite_blit_engine_if;
  logic        ctl_fixed_location;
  logic [31:0] ctl_read_base;
  logic [31:0] ctl_read_length;
  logic        ctl_go;
  logic        ctl_done;
  logic        usr_read_buffer;
  logic [7:0]  usr_buffer_output_data;
  logic        usr_data_available;

  modport master (
    output ctl_fixed_location,
    output ctl_read_base,
    output ctl_read_length,
    output ctl_go,
    input  ctl_done,
    output usr_read_buffer,
    input  usr_buffer_output_data,
    input  usr_data_available
  );

  modport slave (
    input  ctl_fixed_location,
    input  ctl_read_base,
    input  ctl_read_length,
    input  ctl_go,
    output ctl_done,
    input  usr_read_buffer,
    output usr_buffer_output_data,
    output usr_data_available
  );
endinterface

// File: rtl/sprite_blit_engine.sv
// Streams one sprite burst from SDRAM into the frame buffer,
// skipping transparent and off-screen pixels, with optional h/v flips.
module sprite_blit_engine #(
  parameter int         FB_WIDTH    = 640,
  parameter int         FB_HEIGHT   = 480,
  parameter int         FB_ADDR_W   = 19,
  parameter logic [7:0] TRANSPARENT = 8'h00
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic [31:0]          sprite_address,
  input  logic [15:0]          sprite_width,
  input  logic [15:0]          sprite_height,
  input  logic [15:0]          sprite_x,
  input  logic [15:0]          sprite_y,
  input  logic [7:0]           sprite_rotate,
  output logic                 busy,
  output logic                 done,
  sprite_blit_engine_if.master bus,
  output logic                 fb_we,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [7:0]           fb_data
);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    STREAM,
    DRAIN,
    FINISH
  } state_t;

  state_t      state;
  logic [31:0] base;
  logic [31:0] len;
  logic [31:0] count;
  logic [15:0] w;
  logic [15:0] h;
  logic [15:0] x;
  logic [15:0] y;
  logic [15:0] col;
  logic [15:0] row;
  logic        hflip;
  logic        vflip;
  logic        done_seen;
  logic        go;
  logic        pop;
  logic        vis;
  logic [31:0] new_len;
  logic [16:0] xo;
  logic [16:0] yo;
  logic [16:0] dx;
  logic [16:0] dy;
  logic [7:0]  px;
  logic        unused_rot;

  assign unused_rot = ^sprite_rotate[7:2];

  assign new_len = {16'd0, sprite_width}
                 * {16'd0, sprite_height};

  assign px  = bus.usr_buffer_output_data;
  assign pop = (state == STREAM)
             && bus.usr_data_available
             && (count < len);

  assign xo = hflip ? {1'b0, w - 16'd1 - col}
                    : {1'b0, col};
  assign yo = vflip ? {1'b0, h - 16'd1 - row}
                    : {1'b0, row};
  assign dx = {1'b0, x} + xo;
  assign dy = {1'b0, y} + yo;

  assign vis = (px != TRANSPARENT)
             && (dx < 17'(FB_WIDTH))
             && (dy < 17'(FB_HEIGHT));

  assign bus.ctl_fixed_location = 1'b0;
  assign bus.ctl_read_base      = base;
  assign bus.ctl_read_length    = len;
  assign bus.ctl_go             = go;
  assign bus.usr_read_buffer    = pop;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      base      <= '0;
      len       <= '0;
      count     <= '0;
      w         <= '0;
      h         <= '0;
      x         <= '0;
      y         <= '0;
      col       <= '0;
      row       <= '0;
      hflip     <= 1'b0;
      vflip     <= 1'b0;
      done_seen <= 1'b0;
      go        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fb_we     <= 1'b0;
      fb_addr   <= '0;
      fb_data   <= '0;
    end else begin
      go    <= 1'b0;
      done  <= 1'b0;
      fb_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            base      <= sprite_address;
            len       <= new_len;
            w         <= sprite_width;
            h         <= sprite_height;
            x         <= sprite_x;
            y         <= sprite_y;
            hflip     <= sprite_rotate[0];
            vflip     <= sprite_rotate[1];
            col       <= '0;
            row       <= '0;
            count     <= '0;
            done_seen <= 1'b0;
            busy      <= 1'b1;
            go        <= (new_len != 32'd0);
            state     <= (new_len == 32'd0) ? FINISH
                                            : LAUNCH;
          end
        end
        LAUNCH: state <= STREAM;
        STREAM: begin
          if (pop) begin
            fb_we   <= vis;
            fb_addr <= FB_ADDR_W'({15'd0, dy}
                       * 32'(FB_WIDTH)
                       + {15'd0, dx});
            fb_data <= px;
            count   <= count + 32'd1;
            if (col == w - 16'd1) begin
              col <= '0;
              row <= row + 16'd1;
            end else begin
              col <= col + 16'd1;
            end
            if (count + 32'd1 == len) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (done_seen || bus.ctl_done) state <= FINISH;
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // The master may report completion while bytes still sit in its FIFO.
      if ((state == STREAM || state == DRAIN)
          && bus.ctl_done) begin
        done_seen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sprite_blit_engine.sv
// Randomised bench for sprite_blit_engine: SDRAM master model feeds bytes,
// a pixel-level reference predicts the frame buffer write sequence.
module tb_sprite_blit_engine;
  localparam int FBW = 640;
  localparam int FBH = 480;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] saddr = '0;
  logic [15:0] sw = '0;
  logic [15:0] sh = '0;
  logic [15:0] sx = '0;
  logic [15:0] sy = '0;
  logic [7:0]  srot = '0;
  logic        busy;
  logic        done;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic [7:0]  fb_data;

  sprite_blit_engine_if bus();

  sprite_blit_engine dut (
    .Clk(clk),
    .Reset(rst),
    .start(start),
    .sprite_address(saddr),
    .sprite_width(sw),
    .sprite_height(sh),
    .sprite_x(sx),
    .sprite_y(sy),
    .sprite_rotate(srot),
    .busy(busy),
    .done(done),
    .bus(bus),
    .fb_we(fb_we),
    .fb_addr(fb_addr),
    .fb_data(fb_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0]  img[$];
  logic [7:0]  feed[$];
  logic [26:0] obs[$];
  logic [26:0] got[$];
  logic [26:0] exp_w[$];
  int rd = 0;
  int pops = 0;
  int gos = 0;
  int dones = 0;
  int done_dly = 0;
  int gap_pct = 0;
  logic flush = 1'b0;

  int r_pops, r_gos, r_dones, r_left;
  logic r_busy;

  // Read master model: pops happen on the clock edge.
  always @(posedge clk) begin
    if (rst || flush) begin
      rd = feed.size();
    end else if (bus.usr_read_buffer) begin
      rd++;
      pops++;
    end
  end

  always @(negedge clk) begin
    if (fb_we) obs.push_back({fb_addr, fb_data});
    if (done) dones++;
    if (bus.ctl_go) begin
      gos++;
      bus.ctl_done = 1'b0;
      done_dly = $urandom_range(12);
    end else if (done_dly > 0) begin
      done_dly--;
    end else begin
      bus.ctl_done = 1'b1;
    end
    bus.usr_data_available = (rd < feed.size())
      && ($urandom_range(99) >= gap_pct);
    bus.usr_buffer_output_data =
      (rd < feed.size()) ? feed[rd] : 8'hEE;
  end

  // Reference: pixel i sits at (i%w, i/w) of the sprite.
  function automatic void model(input int w, input int h,
                                input int x, input int y,
                                input logic [7:0] rot);
    exp_w.delete();
    for (int i = 0; i < w * h; i++) begin
      int c = i % w;
      int r = i / w;
      int px = x + (rot[0] ? w - 1 - c : c);
      int py = y + (rot[1] ? h - 1 - r : r);
      if (img[i] != 8'h00 && px < FBW && py < FBH)
        exp_w.push_back({19'(py * FBW + px), img[i]});
    end
  endfunction

  function automatic int diff_idx();
    int n = (got.size() < exp_w.size()) ? got.size()
                                        : exp_w.size();
    for (int i = 0; i < n; i++)
      if (got[i] !== exp_w[i]) return i;
    if (got.size() != exp_w.size()) return n;
    return -1;
  endfunction

  function automatic void ramp(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back(8'(i + 1));
  endfunction

  task automatic draw(input int w, input int h,
                      input int x, input int y,
                      input logic [7:0] rot, input int gap);
    int p0, g0, d0, o0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    gap_pct = gap;
    foreach (img[i]) feed.push_back(img[i]);
    repeat (3) feed.push_back(8'h5A);
    p0 = pops; g0 = gos; d0 = dones; o0 = obs.size();
    start = 1'b1;
    saddr = $urandom;
    sw = 16'(w); sh = 16'(h);
    sx = 16'(x); sy = 16'(y);
    srot = rot;
    @(posedge clk); #1;
    start = 1'b0;
    r_busy = busy;
    sw = 16'($urandom); sh = 16'($urandom);
    sx = 16'($urandom); sy = 16'($urandom);
    srot = 8'($urandom);
    for (int c = 0; c < 3000 && dones == d0; c++)
      @(negedge clk);
    repeat (4) @(negedge clk);
    r_pops = pops - p0;
    r_gos = gos - g0;
    r_dones = dones - d0;
    r_left = feed.size() - rd;
    got.delete();
    for (int i = o0; i < obs.size(); i++) got.push_back(obs[i]);
    model(w, h, x, y, rot);
    gap_pct = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, fb_we, fb_addr, fb_data, bus.ctl_go,
         bus.ctl_read_base, bus.ctl_read_length,
         bus.ctl_fixed_location} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b we=%b addr=%0d base=%h len=%0d, required all 0",
               busy, done, fb_we, fb_addr,
               bus.ctl_read_base, bus.ctl_read_length);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    ramp(8);
    draw(4, 2, 10, 20, 8'h00, 0);
    n_checks++;
    if (diff_idx() != -1 || exp_w.size() != 8
        || exp_w[0][26:8] != 19'd12810) begin
      n_fail++;
      $display("FAIL basic_writes: %0d writes, diff at %0d, required %0d",
               got.size(), diff_idx(), exp_w.size());
    end
    n_checks++;
    if (r_pops != 8 || r_left != 3) begin
      n_fail++;
      $display("FAIL basic_pops: pops=%0d left=%0d, required 8 and 3",
               r_pops, r_left);
    end
    n_checks++;
    if (r_gos != 1 || r_dones != 1) begin
      n_fail++;
      $display("FAIL basic_pulses: go=%0d done=%0d, required 1 and 1",
               r_gos, r_dones);
    end
    n_checks++;
    if (r_busy !== 1'b1 || bus.ctl_read_length !== 32'd8) begin
      n_fail++;
      $display("FAIL basic_busy_len: busy=%b len=%0d, required 1 and 8",
               r_busy, bus.ctl_read_length);
    end
  endtask

  task automatic test_flip();
    ramp(8);
    draw(4, 2, 10, 20, 8'h03, 0);
    n_checks++;
    if (diff_idx() != -1 || got.size() < 8
        || got[0] !== {19'd13453, 8'd1}
        || got[7] !== {19'd12810, 8'd8}) begin
      n_fail++;
      $display("FAIL flip_writes: %0d writes, diff at %0d, required %0d",
               got.size(), diff_idx(), exp_w.size());
    end
    n_checks++;
    if (r_pops != 8 || r_dones != 1) begin
      n_fail++;
      $display("FAIL flip_counts: pops=%0d done=%0d, required 8 and 1",
               r_pops, r_dones);
    end
  endtask

  task automatic test_transparent();
    ramp(8);
    img[2] = 8'h00;
    draw(4, 2, 10, 20, 8'h00, 0);
    n_checks++;
    if (diff_idx() != -1 || got.size() != 7) begin
      n_fail++;
      $display("FAIL transp_writes: %0d writes, diff at %0d, required 7",
               got.size(), diff_idx());
    end
    n_checks++;
    if (r_pops != 8) begin
      n_fail++;
      $display("FAIL transp_pops: pops=%0d, required 8", r_pops);
    end
  endtask

  task automatic test_clip();
    ramp(4);
    draw(4, 1, 638, 100, 8'h00, 0);
    n_checks++;
    if (diff_idx() != -1 || got.size() != 2) begin
      n_fail++;
      $display("FAIL clip_writes: %0d writes, diff at %0d, required 2",
               got.size(), diff_idx());
    end
    n_checks++;
    if (r_pops != 4 || r_dones != 1) begin
      n_fail++;
      $display("FAIL clip_counts: pops=%0d done=%0d, required 4 and 1",
               r_pops, r_dones);
    end
  endtask

  task automatic test_zero();
    int g0;
    @(posedge clk); #1;
    g0 = gos;
    start = 1'b1;
    sw = 16'd0; sh = 16'd5;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_accept: done=%b busy=%b, required 0 and 1",
               done, busy);
    end
    // A start raised during the finishing cycle must be dropped.
    sw = 16'd4; sh = 16'd2;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done: done=%b busy=%b, required 1 and 0",
               done, busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_finish_start: done=%b busy=%b, required 0 and 0",
               done, busy);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (gos != g0) begin
      n_fail++;
      $display("FAIL zero_go: go pulses=%0d, required 0", gos - g0);
    end
  endtask

  task automatic test_stall();
    ramp(8);
    draw(4, 2, 10, 20, 8'h00, 50);
    n_checks++;
    if (diff_idx() != -1) begin
      n_fail++;
      $display("FAIL stall_writes: %0d writes, diff at %0d, required %0d",
               got.size(), diff_idx(), exp_w.size());
    end
    n_checks++;
    if (r_pops != 8 || r_dones != 1 || r_gos != 1) begin
      n_fail++;
      $display("FAIL stall_counts: pops=%0d done=%0d go=%0d, required 8 1 1",
               r_pops, r_dones, r_gos);
    end
  endtask

  task automatic test_reset_mid();
    int p0;
    ramp(8);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    foreach (img[i]) feed.push_back(img[i]);
    p0 = pops;
    start = 1'b1;
    sw = 16'd4; sh = 16'd2; sx = 16'd10; sy = 16'd20;
    srot = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 100 && pops - p0 < 3; c++) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (pops - p0 != 3) begin
      n_fail++;
      $display("FAIL rmid_pops: pops=%0d, required 3", pops - p0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || fb_we !== 1'b0 || bus.ctl_go !== 1'b0
        || bus.usr_read_buffer !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_abort: busy=%b we=%b go=%b pop=%b, required 0",
               busy, fb_we, bus.ctl_go, bus.usr_read_buffer);
    end
    rst = 1'b0;
    draw(4, 2, 10, 20, 8'h00, 0);
    n_checks++;
    if (diff_idx() != -1 || r_pops != 8 || r_dones != 1) begin
      n_fail++;
      $display("FAIL rmid_rerun: writes=%0d diff at %0d pops=%0d done=%0d",
               got.size(), diff_idx(), r_pops, r_dones);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      int w = $urandom_range(12, 1);
      int h = $urandom_range(8, 1);
      int x = $urandom_range(660);
      int y = $urandom_range(490);
      logic [7:0] rot = 8'($urandom);
      img.delete();
      for (int i = 0; i < w * h; i++)
        img.push_back(($urandom_range(3) == 0) ? 8'h00
                                               : 8'($urandom));
      draw(w, h, x, y, rot, 30);
      n_checks++;
      if (diff_idx() != -1) begin
        n_fail++;
        $display("FAIL rand_writes[%0d]: %0d writes, diff at %0d, required %0d",
                 t, got.size(), diff_idx(), exp_w.size());
      end
      n_checks++;
      if (r_pops != w * h || r_left != 3 || r_dones != 1) begin
        n_fail++;
        $display("FAIL rand_counts[%0d]: pops=%0d left=%0d done=%0d, required %0d 3 1",
                 t, r_pops, r_left, r_dones, w * h);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flip();
    test_transparent();
    test_clip();
    test_zero();
    test_stall();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
